truth_table_sweeper: RTL

- Hardware counterpart of the team's exhaustive truth-table benches for the 4-input dual-rail functions.
- Drives every input combination onto a combinational function under test, as true and complement rails.
- Samples the function's single output after a programmable settle time and assembles the full truth table.
- Compares the table against an expected vector and reports per-minterm mismatches plus an overall pass flag.

---
 rtl/truth_table_sweeper.sv | 138 +++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps every input vector onto a dual-rail
// function under test, samples its output after a settle delay, and diffs the result against a golden table.

module truth_table_sweeper_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic smp,
  input  logic fin,
  input  logic f_in,
  input  logic exp_bit,
  output logic tbl,
  output logic mis,
  output logic mis_d
);
  // The last minterm is sampled on the same edge that finalizes, so bypass it.
  assign mis_d = (smp ? f_in : tbl) ^ exp_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= 1'b0;
      mis <= 1'b0;
    end else if (clr) begin
      tbl <= 1'b0;
      mis <= 1'b0;
    end else begin
      if (smp) tbl <= f_in;
      if (fin) mis <= mis_d;
    end
  end
endmodule

module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2**N_IN-1:0]    expected,
  output logic [N_IN-1:0]       vec_out,
  output logic [N_IN-1:0]       vec_out_n,
  input  logic                  f_in,
  output logic                  busy,
  output logic                  done,
  output logic [2**N_IN-1:0]    table_out,
  output logic [2**N_IN-1:0]    mismatch,
  output logic                  pass
);
  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t          state, state_d;
  logic [N_IN-1:0] idx, idx_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NV-1:0]   exp_q, mis_d;
  logic            accept, smp, last, fin;

  assign last = (idx == {N_IN{1'b1}});
  assign fin  = smp & last;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    accept  = 1'b0;
    smp     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = HOLD;
        idx_d   = '0;
        cnt_d   = '0;
      end
      HOLD: begin
        if (cnt == CW'(SETTLE)) begin
          smp = 1'b1;
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d = idx + 1'b1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      exp_q <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      if (accept) begin
        exp_q <= expected;
        pass  <= 1'b0;
      end
      if (fin) pass <= ~|mis_d;
    end
  end

  // One capture cell per minterm; only the cell addressed by idx samples.
  for (genvar gi = 0; gi < NV; gi++) begin : g_cell
    truth_table_sweeper_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .smp     (smp && (idx == N_IN'(gi))),
      .fin     (fin),
      .f_in    (f_in),
      .exp_bit (exp_q[gi]),
      .tbl     (table_out[gi]),
      .mis     (mismatch[gi]),
      .mis_d   (mis_d[gi])
    );
  end

  // Rails come straight off the index register, so they are valid through reset.
  assign vec_out   = idx;
  assign vec_out_n = ~idx;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
endmodule
